// File: rtl/timer_rc.sv
// Reconfigurable periodic tick generator: emits a one-cycle Tick every
// (CfgValue+1) enabled cycles, with synchronous Clear and live CfgValue.
module timer_rc #(
    parameter int WIDTH = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Clear,
    input  logic [WIDTH-1:0] CfgValue,
    output logic             Tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic             tick_q;
    logic             tick_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_next  = cnt;
        tick_next = 1'b0;
        if (Clear) begin
            cnt_next = '0;
        end else if (Enable) begin
            // >= rather than == so a CfgValue lowered below cnt wraps on the next enabled edge
            if (cnt >= CfgValue) begin
                cnt_next  = '0;
                tick_next = 1'b1;
            end else begin
                cnt_next = cnt + WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            tick_q <= tick_next;
        end
    end

    assign Tick = tick_q;

endmodule

// File: tb/tb_timer_rc.sv
// Directed self-checking bench for timer_rc: period, CfgValue=0/1, enable gaps,
// Clear priority, live reconfiguration and asynchronous reset.
module tb_timer_rc;

    localparam int WIDTH = 10;

    logic             Clk;
    logic             Rst;
    logic             Enable;
    logic             Clear;
    logic [WIDTH-1:0] CfgValue;
    logic             Tick;

    int checks   = 0;
    int failures = 0;

    timer_rc #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Enable   (Enable),
        .Clear    (Clear),
        .CfgValue (CfgValue),
        .Tick     (Tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // With Enable held high and cnt=0: no Tick for n-1 edges, Tick on the n-th.
    task automatic expect_period(input string tag, input int n);
        int early;
        early = 0;
        for (int i = 0; i < n - 1; i++) begin
            step();
            if (Tick === 1'b1) early++;
        end
        check({tag, "_early"}, early, 0);
        step();
        check({tag, "_tick"}, Tick, 1);
    endtask

    initial begin
        int early;

        // 1. Reset with X on control inputs, then free-running period of 16
        Rst      = 1'b0;
        Enable   = 1'bx;
        Clear    = 1'bx;
        CfgValue = 10'd15;
        step_n(2);
        check("rst_tick", Tick, 0);
        check("rst_cnt", dut.cnt, 0);
        Rst    = 1'b1;
        Enable = 1'b1;
        Clear  = 1'b0;
        expect_period("p16_a", 16);
        step();
        check("p16_fall", Tick, 0);
        expect_period("p16_b", 15);
        check("p16_cnt_wrap", dut.cnt, 0);

        // 2. CfgValue=0 ticks every cycle, CfgValue=1 every second cycle
        CfgValue = 10'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("cfg0_tick", Tick, 1);
        end
        CfgValue = 10'd1;
        step();
        check("cfg1_lo0", Tick, 0);
        step();
        check("cfg1_hi0", Tick, 1);
        step();
        check("cfg1_lo1", Tick, 0);
        step();
        check("cfg1_hi1", Tick, 1);

        // 3. Enable toggling: 16 enabled edges span 32 clocks
        Clear = 1'b1;
        step();
        Clear    = 1'b0;
        CfgValue = 10'd15;
        early    = 0;
        for (int i = 0; i < 15; i++) begin
            Enable = 1'b1;
            step();
            if (Tick === 1'b1) early++;
            Enable = 1'b0;
            step();
            if (Tick === 1'b1) early++;
        end
        check("gap_early", early, 0);
        check("gap_cnt_held", dut.cnt, 15);
        Enable = 1'b1;
        step();
        check("gap_tick", Tick, 1);
        Enable = 1'b0;
        step();
        check("gap_off_fall", Tick, 0);
        check("gap_cnt_wrap", dut.cnt, 0);

        // 4. Clear at cnt=10 restarts the period; Clear on the terminal edge suppresses Tick
        Enable = 1'b1;
        step_n(10);
        check("clr_pre_cnt", dut.cnt, 10);
        Clear = 1'b1;
        step();
        check("clr_cnt", dut.cnt, 0);
        check("clr_tick", Tick, 0);
        Clear = 1'b0;
        expect_period("clr_period", 16);
        step_n(15);
        check("clr_term_pre", dut.cnt, 15);
        Clear = 1'b1;
        step();
        check("clr_term_tick", Tick, 0);
        check("clr_term_cnt", dut.cnt, 0);
        Clear = 1'b0;

        // 5. Live CfgValue: lower below cnt, then raise mid-period
        step_n(10);
        CfgValue = 10'd5;
        step();
        check("lower_tick", Tick, 1);
        check("lower_cnt", dut.cnt, 0);
        expect_period("p6_a", 6);
        expect_period("p6_b", 6);
        step_n(3);
        check("raise_pre_cnt", dut.cnt, 3);
        CfgValue = 10'd20;
        expect_period("raise", 18);

        // 6. Asynchronous reset between edges
        CfgValue = 10'd3;
        step_n(2);
        check("arst_pre_cnt", dut.cnt, 2);
        #2 Rst = 1'b0;
        #1;
        check("arst_cnt", dut.cnt, 0);
        check("arst_tick", Tick, 0);
        step();
        Rst = 1'b1;
        expect_period("arst_full", 4);
        #1 Rst = 1'b0;
        #1;
        check("arst_tick_drop", Tick, 0);
        step();
        Rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
